// File: rtl/cam_fifo_reader.sv
// OV7670 / AL422B FIFO sequencer: captures one frame between two VSYNC rising edges, then
// reads it back as RGB565 byte pairs and emits RGB333 pixels with x/y. Define CAM_BYTE_SWAP_EN for low-byte-first cameras.
module cam_fifo_reader #(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int WRST_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture_en,
  input  logic       ov_vsync,
  input  logic [7:0] fifo_data,
  output logic       fifo_wen,
  output logic       fifo_wrst,
  output logic       rclk,
  output logic       fifo_rrst,
  output logic       fifo_oe,
  output logic       pix_valid,
  output logic [8:0] pix_x,
  output logic [7:0] pix_y,
  output logic [8:0] pix_rgb,
  output logic       frame_done
);

  localparam int CNT_W = (WRST_CYC > 4) ? $clog2(WRST_CYC) + 1 : 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_V = 3'd1,
    WRST   = 3'd2,
    WRITE  = 3'd3,
    RRST   = 3'd4,
    READ   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_vs_s1;
  logic             r_vs_s2;
  logic             r_vs_d;
  logic             w_vs_rise;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_phase;
  logic [7:0]       r_byte0;
  logic [8:0]       r_x;
  logic [7:0]       r_y;
  logic             r_pix_valid;
  logic [8:0]       r_pix_x;
  logic [7:0]       r_pix_y;
  logic [8:0]       r_pix_rgb;
  logic             r_wen;
  logic             r_wrst;
  logic             r_rrst;
  logic             r_oe;
  logic             r_rclk;
  logic             r_frame_done;
  logic             w_wrst_end;
  logic             w_rrst_end;
  logic             w_byte1;
  logic             w_x_last;
  logic             w_last_pix;
  logic [7:0]       w_hi;
  logic [7:0]       w_lo;
  logic [8:0]       w_rgb;
  logic             w_unused;

  // VSYNC is asynchronous: two sync flops, then a third flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_vs_d  <= 1'b0;
    end else begin
      r_vs_s1 <= ov_vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
    end
  end

  assign w_vs_rise  = r_vs_s2 & ~r_vs_d;
  assign w_wrst_end = (r_cnt == CNT_W'(WRST_CYC - 1));
  assign w_rrst_end = (r_cnt == CNT_W'(3));
  assign w_byte1    = (r_phase == 2'd3);
  assign w_x_last   = (r_x == 9'(H_RES - 1));
  assign w_last_pix = w_x_last && (r_y == 8'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (capture_en) w_next = WAIT_V;
      WAIT_V: begin
        if (!capture_en)    w_next = IDLE;
        else if (w_vs_rise) w_next = WRST;
      end
      WRST:    if (w_wrst_end) w_next = WRITE;
      WRITE:   if (w_vs_rise) w_next = RRST;
      RRST:    if (w_rrst_end) w_next = READ;
      READ:    if (w_byte1 && w_last_pix) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_state == WRST || r_state == RRST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef CAM_BYTE_SWAP_EN
  assign w_hi = fifo_data;
  assign w_lo = r_byte0;
`else
  assign w_hi = r_byte0;
  assign w_lo = fifo_data;
`endif

  // RGB565 {hi,lo} = R[4:0]G[5:0]B[4:0]; keep the top 3 bits of each channel.
  assign w_rgb    = {w_hi[7:5], w_hi[2:0], w_lo[4:2]};
  assign w_unused = ^{w_hi[4:3], w_lo[7:5], w_lo[1:0]};

  // Four clk per pixel: phases 0/2 raise rclk, phases 1/3 drop it and sample the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase     <= 2'd0;
      r_byte0     <= 8'd0;
      r_x         <= 9'd0;
      r_y         <= 8'd0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= 9'd0;
      r_pix_y     <= 8'd0;
      r_pix_rgb   <= 9'd0;
    end else begin
      r_pix_valid <= 1'b0;
      if (r_state == READ) begin
        r_phase <= r_phase + 2'd1;
        if (r_phase == 2'd1) r_byte0 <= fifo_data;
        if (w_byte1) begin
          r_pix_valid <= 1'b1;
          r_pix_x     <= r_x;
          r_pix_y     <= r_y;
          r_pix_rgb   <= w_rgb;
          if (w_x_last) begin
            r_x <= 9'd0;
            r_y <= (r_y == 8'(V_RES - 1)) ? 8'd0 : r_y + 8'd1;
          end else begin
            r_x <= r_x + 9'd1;
          end
        end
      end else begin
        r_phase <= 2'd0;
        if (r_state == IDLE) begin
          r_x <= 9'd0;
          r_y <= 8'd0;
        end
      end
    end
  end

  // FIFO strobes are registered from the next state so they line up with state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen        <= 1'b0;
      r_wrst       <= 1'b1;
      r_rrst       <= 1'b1;
      r_oe         <= 1'b1;
      r_rclk       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wen        <= (w_next == WRST) || (w_next == WRITE);
      r_wrst       <= (w_next != WRST);
      r_rrst       <= (w_next != RRST);
      r_oe         <= !((w_next == RRST) || (w_next == READ) || (w_next == DONE));
      r_frame_done <= (r_state == DONE);
      if (r_state == RRST)      r_rclk <= ~r_rclk;
      else if (r_state == READ) r_rclk <= ~r_phase[0];
      else                      r_rclk <= 1'b0;
    end
  end

  assign fifo_wen   = r_wen;
  assign fifo_wrst  = r_wrst;
  assign fifo_rrst  = r_rrst;
  assign fifo_oe    = r_oe;
  assign rclk       = r_rclk;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_rgb    = r_pix_rgb;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_fifo_reader.sv
// Scoreboard bench for cam_fifo_reader on a 4x3 frame with a behavioural AL422B read model.
// Builds with or without CAM_BYTE_SWAP_EN; the FIFO contents are swapped to match.
module tb_cam_fifo_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture_en;
  logic       ov_vsync;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_wen;
  logic       fifo_wrst;
  logic       rclk;
  logic       fifo_rrst;
  logic       fifo_oe;
  logic       pix_valid;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [8:0] pix_rgb;
  logic       frame_done;

  typedef struct {
    int x;
    int y;
    int rgb;
  } pix_t;

  pix_t expq[$];
  pix_t monEntry;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lastValidCyc = 0;
  int   doneCount = 0;
  int   rptr = 0;
  logic [7:0] mem [0:23];

  // Hand-computed RGB565 pairs (high byte, low byte) and their RGB333 result.
  logic [7:0] hiTab  [0:11] = '{8'hF8, 8'h07, 8'h00, 8'hFF, 8'h00, 8'hA5,
                                 8'h12, 8'hE0, 8'h20, 8'h5B, 8'hC6, 8'h3C};
  logic [7:0] loTab  [0:11] = '{8'h00, 8'hE0, 8'h1F, 8'hFF, 8'h00, 8'h5A,
                                 8'h34, 8'h1C, 8'h04, 8'hF3, 8'h6C, 8'hC3};
  int         rgbTab [0:11] = '{'h1C0, 'h038, 'h007, 'h1FF, 'h000, 'h16E,
                                 'h015, 'h1C7, 'h041, 'h09C, 'h1B3, 'h060};

  cam_fifo_reader #(.H_RES(4), .V_RES(3), .WRST_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .ov_vsync   (ov_vsync),
    .fifo_data  (fifo_data),
    .fifo_wen   (fifo_wen),
    .fifo_wrst  (fifo_wrst),
    .rclk       (rclk),
    .fifo_rrst  (fifo_rrst),
    .fifo_oe    (fifo_oe),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // AL422B read side: pointer clears on rclk while rrst is low, data follows each rclk rise.
  always @(posedge rclk) begin
    if (!fifo_rrst) begin
      rptr = 0;
    end else begin
      if (rptr < 24) fifo_data = mem[rptr];
      rptr = rptr + 1;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wen"},   fifo_wen,   0);
    checkOutput({tag, "_wrst"},  fifo_wrst,  1);
    checkOutput({tag, "_rrst"},  fifo_rrst,  1);
    checkOutput({tag, "_oe"},    fifo_oe,    1);
    checkOutput({tag, "_rclk"},  rclk,       0);
    checkOutput({tag, "_valid"}, pix_valid,  0);
    checkOutput({tag, "_x"},     pix_x,      0);
    checkOutput({tag, "_y"},     pix_y,      0);
    checkOutput({tag, "_rgb"},   pix_rgb,    0);
    checkOutput({tag, "_done"},  frame_done, 0);
  endtask

  // Loads the FIFO model with the frame and queues the pixels it must produce.
  task automatic applyStimulus();
    pix_t p;
    for (int i = 0; i < 12; i++) begin
`ifdef CAM_BYTE_SWAP_EN
      mem[2*i]   = loTab[i];
      mem[2*i+1] = hiTab[i];
`else
      mem[2*i]   = hiTab[i];
      mem[2*i+1] = loTab[i];
`endif
      p.x   = i % 4;
      p.y   = i / 4;
      p.rgb = rgbTab[i];
      expq.push_back(p);
    end
  endtask

  task automatic pulseVsync();
    ov_vsync = 1'b1;
    repeat (4) tick();
    ov_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic waitDone(input int target, input int budget);
    int n;
    n = 0;
    while (doneCount < target && n < budget) begin
      tick();
      n++;
    end
    checkOutput("frame_done_count", doneCount, target);
    checkOutput("queue_drained", expq.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every pixel strobe and checks frame_done alignment.
  always @(negedge clk) begin
    if (pix_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pix_valid: got x=%0d y=%0d rgb=0x%0h, expected no pixel", pix_x, pix_y, pix_rgb);
      end else begin
        monEntry = expq.pop_front();
        checkOutput("pix_x", pix_x, monEntry.x);
        checkOutput("pix_y", pix_y, monEntry.y);
        checkOutput("pix_rgb", pix_rgb, monEntry.rgb);
        if (!(monEntry.x == 0 && monEntry.y == 0))
          checkOutput("pix_period", cyc - lastValidCyc, 4);
        lastValidCyc = cyc;
      end
    end
    if (frame_done) begin
      doneCount++;
      checkOutput("done_lag", cyc - lastValidCyc, 1);
      checkOutput("oe_at_done", fifo_oe, 1);
      checkOutput("done_queue_empty", expq.size(), 0);
    end
  end

  initial begin
    rst        = 1'b1;
    capture_en = 1'b0;
    ov_vsync   = 1'b0;
    repeat (3) tick();
    checkReset("reset");
    rst = 1'b0;

    // Disabled capture: VSYNC activity must not start a write.
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) ov_vsync = ~ov_vsync;
      tick();
      checkOutput("idle_wen", fifo_wen, 0);
    end
    ov_vsync = 1'b0;
    repeat (4) tick();
    checkReset("idle");

    // First capture with exact strobe timing.
    applyStimulus();
    capture_en = 1'b1;
    repeat (2) tick();
    ov_vsync = 1'b1;
    repeat (2) tick();
    checkOutput("wrst_before_latency", fifo_wrst, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("wrst_low", fifo_wrst, 0);
      checkOutput("wen_in_wrst", fifo_wen, 1);
      if (i == 2) ov_vsync = 1'b0;
    end
    tick();
    checkOutput("wrst_released", fifo_wrst, 1);
    checkOutput("wen_in_write", fifo_wen, 1);
    repeat (5) tick();
    ov_vsync = 1'b1;
    repeat (2) tick();
    checkOutput("wen_before_latency", fifo_wen, 1);
    tick();
    checkOutput("wen_off", fifo_wen, 0);
    checkOutput("rrst_low", fifo_rrst, 0);
    checkOutput("oe_low_rrst", fifo_oe, 0);
    ov_vsync = 1'b0;
    repeat (3) tick();
    checkOutput("rrst_low_end", fifo_rrst, 0);
    tick();
    checkOutput("rrst_released", fifo_rrst, 1);
    checkOutput("oe_low_read", fifo_oe, 0);
    waitDone(1, 120);
    tick();
    checkOutput("oe_after_done", fifo_oe, 1);

    // Second capture, cut short by reset in the middle of READ.
    applyStimulus();
    pulseVsync();
    repeat (10) tick();
    pulseVsync();
    for (int n = 0; n < 200 && expq.size() > 9; n++) tick();
    checkOutput("partial_pixels", expq.size(), 9);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    checkReset("midrst");
    rst = 1'b0;
    expq.delete();
    repeat (60) tick();
    checkOutput("no_done_after_rst", doneCount, 1);

    // Third capture after reset must complete normally.
    applyStimulus();
    pulseVsync();
    repeat (10) tick();
    pulseVsync();
    waitDone(2, 150);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_fifo_reader.md
# cam_fifo_reader

Upstream stage of the camera path. It sequences the OV7670's AL422B FIFO: it arms a write for exactly one camera frame between two VSYNC edges, then reads the stored frame back byte by byte. Each byte pair is assembled as RGB565 and reduced to the 9-bit RGB333 pixel format used by the canvas. Each pixel is emitted with its x/y coordinate and a one-cycle strobe, for the canvas/frame-buffer stage to store.

## Interface
Parameters:
- H_RES, 320, pixels per line
- V_RES, 240, lines per frame
- WRST_CYC, 8, clk cycles fifo_wrst is held low

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- capture_en  in  1  level; allows a new capture to start
- ov_vsync  in  1  camera VSYNC, asynchronous; 2-flop synchronised internally
- fifo_data  in  8  FIFO read data
- fifo_wen  out  1  FIFO write enable, active high
- fifo_wrst  out  1  FIFO write-pointer reset, active low
- rclk  out  1  FIFO read clock, generated as clk/2 during read
- fifo_rrst  out  1  FIFO read-pointer reset, active low
- fifo_oe  out  1  FIFO output enable, active low
- pix_valid  out  1  one-cycle pixel strobe
- pix_x  out  9  column of the presented pixel
- pix_y  out  8  row of the presented pixel
- pix_rgb  out  9  {R[2:0],G[2:0],B[2:0]}
- frame_done  out  1  one-cycle pulse after the last pixel of a frame

## Operation
- States: IDLE, WAIT_V, WRST, WRITE, RRST, READ, DONE.
- IDLE:
  - All FIFO controls are inactive.
  - Go to WAIT_V when capture_en=1.
- WAIT_V:
  - On a synchronised ov_vsync rising edge, go to WRST.
  - If capture_en drops while in WAIT_V, return to IDLE.
- WRST:
  - fifo_wrst=0 and fifo_wen=1 for WRST_CYC cycles, then go to WRITE.
  - VSYNC edges are ignored in this state.
- WRITE:
  - fifo_wen=1.
  - On the next VSYNC rising edge: fifo_wen←0, go to RRST.
- RRST:
  - fifo_oe=0 and fifo_rrst=0 while rclk toggles for 2 full periods (4 clk).
  - Then fifo_rrst←1 and go to READ.
- READ:
  - fifo_oe=0.
  - Each byte takes 2 clk: phase 0 sets rclk←1; phase 1 sets rclk←0 and samples fifo_data.
  - Byte 0 of each pair is the high byte (R[4:0],G[5:3]); byte 1 is the low byte (G[2:0],B[4:0]).
  - pix_rgb = {R[4:2], G[5:3], B[4:2]}, i.e. truncation with no rounding.
  - After the byte-1 sample, the next cycle gives pix_valid=1 with pix_x, pix_y and pix_rgb held until the next pixel.
  - Counters: x wraps at H_RES-1 to 0 and increments y. After pixel (H_RES-1, V_RES-1), both x and y go to 0 and the state goes to DONE.
- DONE: frame_done=1 for one cycle, fifo_oe←1, go to IDLE.
- capture_en is sampled only in IDLE and WAIT_V. A frame already being written or read always completes.

## Timing
- Reset values:
  - fifo_wen=0, fifo_wrst=1, fifo_rrst=1, fifo_oe=1, rclk=0.
  - pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0, frame_done=0.
  - State is IDLE.
- rst mid-frame: every output takes its reset value on the next clk edge. The partial frame is discarded and no frame_done is generated.
- VSYNC latency: a pin edge is acted on 3 clk after it (2 sync flops + 1 edge-detect register).
- Pixel rate: one pix_valid every 4 clk. A frame read is 4·H_RES·V_RES clk (307200 at default).
- The first pix_valid occurs 4 clk after entering READ. frame_done occurs 1 cycle after the last pix_valid.
- pix_valid is never asserted outside READ. There is no back-pressure: the downstream stage must accept a pixel every 4 clk.

## Configuration
- CAM_BYTE_SWAP_EN, when defined: byte 0 of each pair is treated as the low byte and byte 1 as the high byte. This matches a camera programmed with swapped RGB565 output.
- CAM_BYTE_SWAP_EN, when undefined: high byte first, as described above.
- The macro changes nothing else, including timing.

## Test plan
- Reset, then capture_en=0 with VSYNC toggling → all outputs hold reset values and fifo_wen stays 0.
- capture_en=1, then two VSYNC rising edges → fifo_wrst is low for 8 clk starting 3 clk after the first edge. fifo_wen is 1 from the wrst pulse until 3 clk after the second edge.
- FIFO model returns byte pairs 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F → pix_rgb = 0x1C0, 0x038, 0x007 at (0,0), (1,0), (2,0), with pix_valid exactly every 4 clk.
- Full frame at H_RES=4, V_RES=3 → 12 pix_valid pulses. Coordinates run (3,0)→(0,1) and wrap after (3,2). frame_done occurs 1 clk after the 12th pixel, then fifo_oe=1.
- rst asserted during READ → all outputs are at reset values on the next edge and no frame_done is generated. A subsequent capture works normally.
- With CAM_BYTE_SWAP_EN, bytes 0x00,0xF8 → pix_rgb=0x1C0.
